// File: rtl/prog_loader_pkg.sv
// Shared constants, state encoding and helpers for the program loader and its instruction RAM.
package prog_loader_pkg;

  localparam int DEPTH        = 16;
  localparam int INS_W        = 16;
  localparam int NIB_W        = 4;
  localparam int NIB_PER_WORD = INS_W / NIB_W;
  localparam int ADDR_W       = $clog2(DEPTH);
  localparam int CNT_W        = $clog2(NIB_PER_WORD);
  localparam int LEN_W        = ADDR_W + 1;

  localparam logic [INS_W-1:0] RESET_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Requested lengths beyond the RAM depth saturate at a full-RAM load.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  endfunction

endpackage

// File: rtl/ins_ram.sv
// DEPTH x INS_W instruction store: one synchronous write port, one combinational read port.
module ins_ram
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [INS_W-1:0]  WDATA,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [INS_W-1:0]  RDATA
);

  logic [INS_W-1:0] mem_q [DEPTH];

  // NOTE: this store is a small flop array, so it can and must be cleared on reset;
  // a macro SRAM could not be, and a cleared program is what the CPU fetches after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_WORD;
      end
    end else if (we) begin
      mem_q[WADDR] <= WDATA;
    end
  end

  // Read-during-write returns the old word because the write lands at the edge.
  assign RDATA = mem_q[RADDR];

endmodule

// File: rtl/prog_loader.sv
// Load controller: assembles nibble streams into instruction words, fills ins_ram,
// and holds the CPU program counter in reset until the load finishes.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [LEN_W-1:0]  LOAD_LEN,
  input  logic [NIB_W-1:0]  NIB_IN,
  input  logic              nib_valid,
  output logic              nib_ready,
  input  logic [ADDR_W-1:0] PC,
  output logic [INS_W-1:0]  RES_INS,
  output logic              set_pc,
  output logic              loading,
  output logic              load_done
);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [CNT_W-1:0]         nib_cnt_q, nib_cnt_d;
  logic [INS_W-NIB_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     done_q, done_d;

  logic                     we;
  logic [INS_W-1:0]         wdata;
  logic [LEN_W-1:0]         start_len;
  logic                     start_ok;
  logic                     xfer;
  logic                     last_nib;
  logic                     last_word;

  assign start_len = eff_len(LOAD_LEN);
  assign start_ok  = load_start && (start_len != '0);
  assign xfer      = (state_q == LOAD) && nib_valid;
  assign last_nib  = (nib_cnt_q == CNT_W'(NIB_PER_WORD - 1));
  assign last_word = ((LEN_W'(addr_q) + LEN_W'(1)) == len_q);
  // The fourth nibble goes straight into the write data, so only three are ever held.
  assign wdata     = {shift_q, NIB_IN};

  // NOTE: every signal driven here gets its default first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    nib_cnt_d = nib_cnt_q;
    shift_d   = shift_q;
    len_d     = len_q;
    done_d    = 1'b0;
    we        = 1'b0;

    if (start_ok) begin
      // Starting or restarting: a nibble offered this cycle is dropped.
      state_d   = LOAD;
      addr_d    = '0;
      nib_cnt_d = '0;
      shift_d   = '0;
      len_d     = start_len;
    end else if (xfer) begin
      shift_d   = wdata[INS_W-NIB_W-1:0];
      nib_cnt_d = nib_cnt_q + CNT_W'(1);
      if (last_nib) begin
        we        = 1'b1;
        addr_d    = addr_q + ADDR_W'(1);
        nib_cnt_d = '0;
        if (last_word) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      nib_cnt_q <= '0;
      shift_q   <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      nib_cnt_q <= nib_cnt_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      done_q    <= done_d;
    end
  end

  assign nib_ready = (state_q == LOAD);
  assign loading   = (state_q == LOAD);
  assign set_pc    = (state_q != RUN);
  assign load_done = done_q;

  ins_ram u_ins_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .WADDR (addr_q),
    .WDATA (wdata),
    .RADDR (PC),
    .RDATA (RES_INS)
  );

endmodule
